// File: rtl/clk_sel_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : clk_sel_ctrl
//  Description : Clock-source select controller for a downstream glitch-free
//                clock mux. Accepts switch requests, waits for the target PLL
//                to report lock, drives the registered select, holds for a
//                settle window, and fails over autonomously when the active
//                PLL loses lock while the other one is locked.
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_sel_ctrl #(
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_CYCLES = 16,
    parameter int LOCK_TIMEOUT  = 256,
    parameter int AUTO_FAILOVER = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_valid_i,
    input  logic req_sel_i,
    output logic req_ready_o,
    input  logic pll_1_lock_i,
    input  logic pll_2_lock_i,
    output logic sel_o,
    output logic busy_o,
    output logic done_o,
    output logic err_o,
    output logic failover_o
);

    // Counter is shared by the lock wait and the settle window; it only ever
    // reaches (limit - 1), so sizing for CNT_MAX + 1 can never wrap.
    localparam int CNT_MAX = (SETTLE_CYCLES > LOCK_TIMEOUT) ? SETTLE_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic             FAILOVER_EN  = (AUTO_FAILOVER != 0);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_SWITCH    = 3'd2,
        ST_DONE      = 3'd3,
        ST_ERR       = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic                   sel_q, sel_d;
    logic                   target_q, target_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   failover_q, failover_d;
    logic [SYNC_STAGES-1:0] sync1_q, sync1_d;
    logic [SYNC_STAGES-1:0] sync2_q, sync2_d;

    logic lock1_s;
    logic lock2_s;
    logic active_lock;
    logic other_lock;
    logic target_lock;
    logic failover_trig;

    // Shift the raw lock levels into their synchronisers; last stage is the
    // only version of lock the control logic ever looks at.
    always_comb begin
        sync1_d = {sync1_q[SYNC_STAGES-2:0], pll_1_lock_i};
        sync2_d = {sync2_q[SYNC_STAGES-2:0], pll_2_lock_i};
    end

    assign lock1_s     = sync1_q[SYNC_STAGES-1];
    assign lock2_s     = sync2_q[SYNC_STAGES-1];
    assign active_lock = sel_q    ? lock2_s : lock1_s;
    assign other_lock  = sel_q    ? lock1_s : lock2_s;
    assign target_lock = target_q ? lock2_s : lock1_s;

    // Failover only fires from IDLE and only when there is a locked source
    // to move to; with both PLLs down the select is left where it is.
    assign failover_trig = FAILOVER_EN && (state_q == ST_IDLE) && !active_lock && other_lock;

    assign req_ready_o = (state_q == ST_IDLE) && !failover_trig;
    assign busy_o      = (state_q != ST_IDLE);
    assign sel_o       = sel_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign failover_o  = failover_q;

    // Next-state and next-output computation for the switch sequencer.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        target_d   = target_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        failover_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (failover_trig) begin
                    // Select flips on the same edge we enter SWITCH.
                    state_d    = ST_SWITCH;
                    target_d   = ~sel_q;
                    sel_d      = ~sel_q;
                    cnt_d      = '0;
                    failover_d = 1'b1;
                end else if (req_valid_i) begin
                    target_d = req_sel_i;
                    if (req_sel_i == sel_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end
                end
            end
            ST_WAIT_LOCK: begin
                if (target_lock) begin
                    state_d = ST_SWITCH;
                    sel_d   = target_q;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = ST_ERR;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_SWITCH: begin
                // Lock inputs are deliberately not consulted here: once the
                // mux select has moved the settle window always runs out.
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer state, registered status pulses and lock synchronisers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            sel_q      <= 1'b0;
            target_q   <= 1'b0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            failover_q <= 1'b0;
            sync1_q    <= '0;
            sync2_q    <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            target_q   <= target_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
            failover_q <= failover_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_sel_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clk_sel_ctrl
//  Description : Self-checking bench for clk_sel_ctrl: directed reset, switch,
//                timeout, same-source, failover and mid-switch reset steps,
//                then randomized lock/request traffic against a latency model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_sel_ctrl;

    localparam int SYNC_STAGES   = 2;
    localparam int SETTLE_CYCLES = 16;
    localparam int LOCK_TIMEOUT  = 256;
    localparam int AUTO_FAILOVER = 1;

    logic clk = 1'b0;
    logic rst;
    logic req_valid;
    logic req_sel;
    logic req_ready;
    logic pll1;
    logic pll2;
    logic sel;
    logic busy;
    logic done;
    logic err;
    logic fo;

    int n_cmp = 0;
    int n_bad = 0;

    // Model of the observable select and the synchronised lock levels.
    logic m_sel;
    logic m_lk1;
    logic m_lk2;

    always #5 clk = ~clk;

    clk_sel_ctrl #(
        .SYNC_STAGES  (SYNC_STAGES),
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .AUTO_FAILOVER(AUTO_FAILOVER)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_sel_i   (req_sel),
        .req_ready_o (req_ready),
        .pll_1_lock_i(pll1),
        .pll_2_lock_i(pll2),
        .sel_o       (sel),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .failover_o  (fo)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_n(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One rising edge, then park on the falling edge to sample and drive.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue one request from IDLE and check every cycle against the latency
    // the rules predict: same source -> DONE next cycle; locked target ->
    // select moves at cycle 2, DONE at 2+SETTLE; unlocked -> ERR at TIMEOUT+1.
    task automatic do_req(input logic tgt, input string tag);
        int  sc;
        int  dc;
        int  ec;
        int  endc;
        logic old;
        old = m_sel;
        sc  = -1;
        dc  = -1;
        ec  = -1;
        if (tgt == old) begin
            dc = 1;
        end else if (tgt ? m_lk2 : m_lk1) begin
            sc = 2;
            dc = 2 + SETTLE_CYCLES;
        end else begin
            ec = LOCK_TIMEOUT + 1;
        end
        endc = (dc > 0) ? dc : ec;
        chk({tag, "_ready_pre"}, req_ready, 1'b1);
        req_valid = 1'b1;
        req_sel   = tgt;
        step();
        req_valid = 1'b0;
        for (int n = 1; n <= endc + 1; n++) begin
            if (n > 1) step();
            chk($sformatf("%s_c%0d_sel", tag, n), sel, (sc > 0 && n >= sc) ? tgt : old);
            chk($sformatf("%s_c%0d_done", tag, n), done, n == dc);
            chk($sformatf("%s_c%0d_err", tag, n), err, n == ec);
            chk($sformatf("%s_c%0d_busy", tag, n), busy, n <= endc);
            chk($sformatf("%s_c%0d_fo", tag, n), fo, 1'b0);
            chk($sformatf("%s_c%0d_ready", tag, n), req_ready, n > endc);
        end
        if (sc > 0) m_sel = tgt;
    endtask

    // Change the lock levels while idle and let any failover run its course.
    task automatic set_locks(input logic l1, input logic l2, input string tag);
        int   nfo;
        int   ndone;
        int   exp_fo;
        logic act;
        logic oth;
        nfo   = 0;
        ndone = 0;
        pll1  = l1;
        pll2  = l2;
        m_lk1 = l1;
        m_lk2 = l2;
        for (int n = 0; n < SYNC_STAGES + SETTLE_CYCLES + 6; n++) begin
            step();
            nfo   += int'(fo);
            ndone += int'(done);
        end
        act    = m_sel ? m_lk2 : m_lk1;
        oth    = m_sel ? m_lk1 : m_lk2;
        exp_fo = (AUTO_FAILOVER != 0 && !act && oth) ? 1 : 0;
        if (exp_fo == 1) m_sel = ~m_sel;
        chk_n({tag, "_fo_count"}, nfo, exp_fo);
        chk_n({tag, "_done_count"}, ndone, exp_fo);
        chk({tag, "_sel"}, sel, m_sel);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_ready"}, req_ready, 1'b1);
    endtask

    initial begin
        int ndone;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_sel   = 1'b0;
        pll1      = 1'b1;
        pll2      = 1'b1;
        m_sel     = 1'b0;
        m_lk1     = 1'b1;
        m_lk2     = 1'b1;

        // Reset held three cycles, then released.
        repeat (3) step();
        rst = 1'b0;
        chk("rst_sel", sel, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_fo", fo, 1'b0);
        repeat (SYNC_STAGES + 2) step();

        // Same-source request, normal switch to PLL2 and back to PLL1.
        do_req(1'b0, "same_src");
        do_req(1'b1, "sw_to_2");
        do_req(1'b0, "sw_to_1");

        // Lock timeout toward an unlocked PLL2.
        set_locks(1'b1, 1'b0, "lk_10");
        do_req(1'b1, "timeout");

        // Failover with a request raised in the triggering cycle.
        set_locks(1'b1, 1'b1, "lk_11");
        pll1  = 1'b0;
        m_lk1 = 1'b0;
        step();
        chk("fo_ready_pre", req_ready, 1'b1);
        chk("fo_pulse_pre", fo, 1'b0);
        step();
        chk("fo_ready_blocked", req_ready, 1'b0);
        chk("fo_busy_pre", busy, 1'b0);
        req_valid = 1'b1;
        req_sel   = 1'b0;
        step();
        req_valid = 1'b0;
        chk("fo_pulse", fo, 1'b1);
        chk("fo_sel", sel, 1'b1);
        chk("fo_busy", busy, 1'b1);
        chk("fo_done_early", done, 1'b0);
        for (int n = 1; n <= SETTLE_CYCLES; n++) begin
            step();
            chk($sformatf("fo_c%0d_done", n), done, n == SETTLE_CYCLES);
            chk($sformatf("fo_c%0d_fo", n), fo, 1'b0);
            chk($sformatf("fo_c%0d_sel", n), sel, 1'b1);
        end
        step();
        chk("fo_idle_busy", busy, 1'b0);
        chk("fo_idle_ready", req_ready, 1'b1);
        m_sel = 1'b1;

        // Reset five cycles into a switch toward PLL2.
        set_locks(1'b1, 1'b1, "lk_11b");
        rst = 1'b1;
        step();
        rst   = 1'b0;
        m_sel = 1'b0;
        chk("rst2_sel", sel, 1'b0);
        repeat (SYNC_STAGES + 2) step();
        req_valid = 1'b1;
        req_sel   = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        chk("midsw_sel_switched", sel, 1'b1);
        repeat (4) step();
        chk("midsw_busy_before", busy, 1'b1);
        rst = 1'b1;
        step();
        chk("midsw_rst_sel", sel, 1'b0);
        chk("midsw_rst_busy", busy, 1'b0);
        chk("midsw_rst_done", done, 1'b0);
        rst   = 1'b0;
        ndone = 0;
        for (int n = 0; n < SETTLE_CYCLES + 10; n++) begin
            step();
            ndone += int'(done);
        end
        chk_n("midsw_done_count", ndone, 0);
        chk("midsw_final_sel", sel, 1'b0);

        // Randomized lock changes and requests.
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                set_locks(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          $sformatf("rnd%0d_lk", i));
            end else begin
                do_req(1'($urandom_range(0, 1)), $sformatf("rnd%0d_req", i));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clk_sel_ctrl.md
CLK_SEL_CTRL -- requirements
Module: clk_sel_ctrl

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, giving the number of synchroniser flops per lock input (legal values 2 or more).
REQ-002 The block SHALL have parameter SETTLE_CYCLES, default 16, giving the clk_i cycles held in SWITCH after sel_o changes (legal values 3 or more).
REQ-003 The block SHALL have parameter LOCK_TIMEOUT, default 256, giving the maximum WAIT_LOCK cycles before error (legal values 1 or more).
REQ-004 The block SHALL have parameter AUTO_FAILOVER, default 1, which when 1 enables autonomous switch away from an unlocked active source.
REQ-005 The block SHALL have port clk_i, input, 1 bit: single control clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have ports req_valid_i (input, 1), req_sel_i (input, 1) and req_ready_o (output, 1): the switch request handshake; req_sel_i=0 selects PLL1 and 1 selects PLL2.
REQ-008 The block SHALL have ports pll_1_lock_i and pll_2_lock_i, input, 1 bit each: asynchronous PLL lock indicators.
REQ-009 The block SHALL have port sel_o, output, 1 bit: registered select that drives the downstream glitch-free clock mux sel_i.
REQ-010 The block SHALL have ports busy_o, done_o, err_o and failover_o, output, 1 bit each: status outputs; done_o, err_o and failover_o are single-cycle pulses.

Function
REQ-011 Each lock input SHALL pass through a SYNC_STAGES flop synchroniser, giving lock1_s and lock2_s; only these synchronised values are used internally.
REQ-012 The FSM SHALL have exactly five states: IDLE, WAIT_LOCK, SWITCH, DONE and ERR; busy_o SHALL equal (state != IDLE).
REQ-013 req_ready_o SHALL be 1 only in IDLE when no failover is triggering in that cycle; a request is accepted on a rising edge with req_valid_i=1 and req_ready_o=1, and req_sel_i is captured as target.
REQ-014 On acceptance with target == sel_o, the next state SHALL be DONE, with no change to sel_o.
REQ-015 On acceptance with target != sel_o, the next state SHALL be WAIT_LOCK and the counter SHALL clear to 0.
REQ-016 WAIT_LOCK SHALL behave as follows each cycle:
- if the target lock_s is 1, go to SWITCH;
- else if the counter equals LOCK_TIMEOUT-1, go to ERR;
- else increment the counter.
REQ-017 On entry to SWITCH, sel_o SHALL take the value target at that same edge; the counter clears and SWITCH lasts exactly SETTLE_CYCLES cycles, then goes to DONE.
REQ-018 In SWITCH, lock changes SHALL be ignored and the switch SHALL complete.
REQ-019 DONE SHALL last one cycle with done_o=1, then return to IDLE.
REQ-020 ERR SHALL last one cycle with err_o=1, leave sel_o unchanged, then return to IDLE.
REQ-021 Failover SHALL trigger in IDLE when AUTO_FAILOVER=1, the active lock_s=0 and the other lock_s=1.
- It takes priority over a simultaneous request; req_ready_o is 0 that cycle.
- Next state is SWITCH with target = ~sel_o.
- failover_o=1 on the SWITCH entry cycle.
REQ-022 Failover SHALL NOT trigger when both lock_s are 0; sel_o SHALL hold.
REQ-023 The counter width SHALL be sufficient for max(SETTLE_CYCLES, LOCK_TIMEOUT) with no wrap-around.

Reset
REQ-024 While rst_i=1 at a rising edge, the block SHALL set: state=IDLE, sel_o=0, counter=0, target=0, done_o=0, err_o=0, failover_o=0, busy_o=0 and synchroniser flops=0.
REQ-025 A reset in any state, including mid-SWITCH, SHALL return sel_o to 0 at that edge and SHALL discard the pending request.
REQ-026 req_ready_o SHALL be 1 in the first cycle after rst_i deasserts, unless failover is triggering; synchroniser flops reset to 0, so failover cannot trigger in that cycle.

Verification (defaults; accept edge = cycle 0)
REQ-027 Reset check: rst_i=1 for 3 cycles, then 0 -> sel_o=0, busy_o=0, req_ready_o=1, done_o=err_o=failover_o=0.
REQ-028 Normal switch: lock2_s=1, request sel=1 -> WAIT_LOCK at cycle 1; sel_o=1 from cycle 2; done_o=1 at cycle 18 only; req_ready_o=1 at cycle 19.
REQ-029 Lock timeout: pll_2_lock_i=0, request sel=1 -> err_o=1 at cycle 257 only; sel_o stays 0 throughout; IDLE at cycle 258.
REQ-030 Same-source request: sel_o=0, request sel=0 -> done_o=1 at cycle 1; busy_o=1 only at cycle 1; sel_o never changes.
REQ-031 Failover: sel_o=0 and pll_2_lock_i=1 in IDLE; drop pll_1_lock_i while holding req_valid_i=1 -> after 2 sync cycles failover_o=1 and sel_o=1 on the same edge; the request is not accepted; done_o=1 16 cycles later.
REQ-032 Reset mid-SWITCH: assert rst_i 5 cycles into SWITCH toward PLL2 -> sel_o=0 at the next edge; done_o never pulses.
